// File: rtl/tictactoe_pkg.sv
// Shared cell/result codes and controller state encoding for the tic-tac-toe datapath.
package tictactoe_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [3:0] NUM_CELLS = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    P1_TURN,
    P2_TURN,
    CHECK,
    OVER
  } state_t;

  // Turn state that follows a move by the given player.
  function automatic state_t next_turn(input logic [1:0] mover);
    return (mover == CELL_P1) ? P2_TURN : P1_TURN;
  endfunction

endpackage

// File: rtl/tictactoe_board_ctrl_turn_timer.sv
// Per-turn cycle counter; expired is high while the count sits at TIMEOUT_CYCLES-1.
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // An expiry cycle that does not clear (e.g. a rejected move) wraps to 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= expired ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tictactoe_board_ctrl.sv
// Board writer: validates moves, alternates turns, auto-moves on timeout and resolves win/draw.
module tictactoe_board_ctrl
  import tictactoe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic       winner,
  input  logic [1:0] who,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic       move_ack,
  output logic       move_err,
  output logic       game_over,
  output logic [1:0] result
);

  state_t     state, state_next;
  logic [1:0] board [9];
  logic [3:0] move_cnt, cnt_next;
  logic [1:0] mover, mover_next;
  logic [1:0] res_next;

  logic       do_write, do_err;
  logic [3:0] write_idx;
  logic [1:0] cur_code;

  logic       in_turn, expired;
  logic       pos_ok, target_free;
  logic [3:0] pos_idx;
  logic       empty_found;
  logic [3:0] empty_idx;

  assign in_turn  = (state == P1_TURN) || (state == P2_TURN);
  assign cur_code = (state == P2_TURN) ? CELL_P2 : CELL_P1;

  assign pos_idx     = move_pos - 4'd1;
  assign pos_ok      = (move_pos != 4'd0) && (move_pos <= NUM_CELLS);
  assign target_free = pos_ok && (board[pos_idx] == CELL_EMPTY);

  // Priority encoder: scanning downwards leaves the lowest empty index.
  always_comb begin
    empty_found = 1'b0;
    empty_idx   = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (board[i] == CELL_EMPTY) begin
        empty_found = 1'b1;
        empty_idx   = 4'(i);
      end
    end
  end

  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (new_game || do_write),
    .en     (in_turn),
    .expired(expired)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = move_cnt;
    mover_next = mover;
    res_next   = result;
    do_write   = 1'b0;
    do_err     = 1'b0;
    write_idx  = 4'd0;

    case (state)
      P1_TURN, P2_TURN: begin
        if (move_valid) begin
          if (target_free) begin
            do_write  = 1'b1;
            write_idx = pos_idx;
          end else begin
            do_err = 1'b1;
          end
        end else if (expired && empty_found) begin
          do_write  = 1'b1;
          write_idx = empty_idx;
        end
        if (do_write) begin
          cnt_next   = (move_cnt == NUM_CELLS) ? move_cnt : move_cnt + 4'd1;
          mover_next = cur_code;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (winner) begin
          res_next   = who;
          state_next = OVER;
        end else if (move_cnt == NUM_CELLS) begin
          res_next   = RES_DRAW;
          state_next = OVER;
        end else begin
          state_next = next_turn(mover);
        end
      end
      default: ;
    endcase

    if (new_game) begin
      state_next = P1_TURN;
      cnt_next   = 4'd0;
      mover_next = CELL_P1;
      res_next   = RES_NONE;
      do_write   = 1'b0;
      do_err     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      move_cnt <= 4'd0;
      mover    <= CELL_P1;
      result   <= RES_NONE;
      turn     <= CELL_EMPTY;
      move_ack <= 1'b0;
      move_err <= 1'b0;
      for (int i = 0; i < 9; i++) board[i] <= CELL_EMPTY;
    end else begin
      state    <= state_next;
      move_cnt <= cnt_next;
      mover    <= mover_next;
      result   <= res_next;
      move_ack <= do_write;
      move_err <= do_err;
      turn     <= (state_next == P1_TURN) ? CELL_P1 :
                  (state_next == P2_TURN) ? CELL_P2 : CELL_EMPTY;
      if (new_game) begin
        for (int i = 0; i < 9; i++) board[i] <= CELL_EMPTY;
      end else if (do_write) begin
        board[write_idx] <= cur_code;
      end
    end
  end

  assign game_over = (state == OVER);

  assign pos1 = board[0];
  assign pos2 = board[1];
  assign pos3 = board[2];
  assign pos4 = board[3];
  assign pos5 = board[4];
  assign pos6 = board[5];
  assign pos7 = board[6];
  assign pos8 = board[7];
  assign pos9 = board[8];

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Directed bench for tictactoe_board_ctrl with a behavioural winner detector closing the loop.
module tb_tictactoe_board_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst, new_game, move_valid;
  logic [3:0] move_pos;
  logic       winner;
  logic [1:0] who;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] turn, result;
  logic       move_ack, move_err, game_over;
  logic [1:0] cells [1:9];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tictactoe_board_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .winner(winner), .who(who),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .turn(turn), .move_ack(move_ack), .move_err(move_err),
    .game_over(game_over), .result(result)
  );

  assign cells[1] = pos1; assign cells[2] = pos2; assign cells[3] = pos3;
  assign cells[4] = pos4; assign cells[5] = pos5; assign cells[6] = pos6;
  assign cells[7] = pos7; assign cells[8] = pos8; assign cells[9] = pos9;

  // Stand-in for winner_detector: any complete line of one non-empty code.
  always_comb begin
    winner = 1'b0;
    who    = 2'b00;
    for (int l = 0; l < 8; l++) begin
      int a, b, c;
      case (l)
        0: begin a = 1; b = 2; c = 3; end
        1: begin a = 4; b = 5; c = 6; end
        2: begin a = 7; b = 8; c = 9; end
        3: begin a = 1; b = 4; c = 7; end
        4: begin a = 2; b = 5; c = 8; end
        5: begin a = 3; b = 6; c = 9; end
        6: begin a = 1; b = 5; c = 9; end
        default: begin a = 3; b = 5; c = 7; end
      endcase
      if (cells[a] != 2'b00 && cells[a] == cells[b] && cells[b] == cells[c]) begin
        winner = 1'b1;
        who    = cells[a];
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Accepted move: ack and cell after one edge, turn after the CHECK edge.
  task automatic do_move(input int p, input logic [1:0] code, input logic [1:0] turn_after);
    move_valid = 1'b1;
    move_pos   = 4'(p);
    tick();
    move_valid = 1'b0;
    check($sformatf("ack_m%0d", p), {7'd0, move_ack}, 8'd1);
    check($sformatf("cell_m%0d", p), {6'd0, cells[p]}, {6'd0, code});
    check($sformatf("chk_turn_m%0d", p), {6'd0, turn}, 8'd0);
    tick();
    check($sformatf("turn_after_m%0d", p), {6'd0, turn}, {6'd0, turn_after});
  endtask

  task automatic bad_move(input int p);
    move_valid = 1'b1;
    move_pos   = 4'(p);
    tick();
    move_valid = 1'b0;
    check($sformatf("err_p%0d", p), {7'd0, move_err}, 8'd1);
    check($sformatf("noack_p%0d", p), {7'd0, move_ack}, 8'd0);
    check($sformatf("turn_p%0d", p), {6'd0, turn}, 8'h02);
    check($sformatf("pos1_p%0d", p), {6'd0, pos1}, 8'h01);
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b1; move_valid = 1'b0; move_pos = 4'd0;
    tick();
    // reset overrides new_game
    check("rst_turn", {6'd0, turn}, 8'd0);
    check("rst_over", {7'd0, game_over}, 8'd0);
    check("rst_result", {6'd0, result}, 8'd0);
    check("rst_pos1", {6'd0, pos1}, 8'd0);
    check("rst_ack", {7'd0, move_ack}, 8'd0);
    check("rst_err", {7'd0, move_err}, 8'd0);
    rst = 1'b0; new_game = 1'b0;

    // move in IDLE is ignored
    move_valid = 1'b1; move_pos = 4'd5;
    tick();
    move_valid = 1'b0;
    check("idle_ack", {7'd0, move_ack}, 8'd0);
    check("idle_err", {7'd0, move_err}, 8'd0);
    check("idle_pos5", {6'd0, pos5}, 8'd0);

    // Game 1: P1 wins on the top row
    new_game = 1'b1; tick(); new_game = 1'b0;
    check("ng_turn", {6'd0, turn}, 8'h01);
    do_move(1, 2'b01, 2'b10);
    do_move(4, 2'b10, 2'b01);
    do_move(2, 2'b01, 2'b10);
    do_move(5, 2'b10, 2'b01);
    do_move(3, 2'b01, 2'b00);
    check("g1_result", {6'd0, result}, 8'h01);
    check("g1_over", {7'd0, game_over}, 8'd1);
    check("g1_pos2", {6'd0, pos2}, 8'h01);

    // moves in OVER are ignored and the board holds
    move_valid = 1'b1; move_pos = 4'd9;
    tick();
    move_valid = 1'b0;
    check("over_ack", {7'd0, move_ack}, 8'd0);
    check("over_err", {7'd0, move_err}, 8'd0);
    check("over_pos9", {6'd0, pos9}, 8'd0);
    check("over_hold", {6'd0, result}, 8'h01);

    // new_game from OVER
    new_game = 1'b1; tick(); new_game = 1'b0;
    check("ngo_pos1", {6'd0, pos1}, 8'd0);
    check("ngo_turn", {6'd0, turn}, 8'h01);
    check("ngo_result", {6'd0, result}, 8'd0);
    check("ngo_over", {7'd0, game_over}, 8'd0);

    // Game 2: draw after nine moves
    do_move(5, 2'b01, 2'b10);
    do_move(1, 2'b10, 2'b01);
    do_move(9, 2'b01, 2'b10);
    do_move(3, 2'b10, 2'b01);
    do_move(2, 2'b01, 2'b10);
    do_move(8, 2'b10, 2'b01);
    do_move(7, 2'b01, 2'b10);
    do_move(4, 2'b10, 2'b01);
    do_move(6, 2'b01, 2'b00);
    check("g2_result", {6'd0, result}, 8'h03);
    check("g2_over", {7'd0, game_over}, 8'd1);

    // Game 3: rejected moves by P2, then new_game during CHECK
    new_game = 1'b1; tick(); new_game = 1'b0;
    do_move(1, 2'b01, 2'b10);
    bad_move(1);
    bad_move(0);
    bad_move(12);
    tick();
    check("err_one_cycle", {7'd0, move_err}, 8'd0);
    move_valid = 1'b1; move_pos = 4'd5;
    tick();
    move_valid = 1'b0;
    check("g3_ack", {7'd0, move_ack}, 8'd1);
    new_game = 1'b1; tick(); new_game = 1'b0;
    check("ngc_pos5", {6'd0, pos5}, 8'd0);
    check("ngc_pos1", {6'd0, pos1}, 8'd0);
    check("ngc_turn", {6'd0, turn}, 8'h01);

    // Game 4: timeouts, starting from the new_game edge above
    tick(TO - 1);
    check("to1_pre_pos1", {6'd0, pos1}, 8'd0);
    check("to1_pre_ack", {7'd0, move_ack}, 8'd0);
    tick();
    check("to1_pos1", {6'd0, pos1}, 8'h01);
    check("to1_ack", {7'd0, move_ack}, 8'd1);
    tick();
    check("to1_turn", {6'd0, turn}, 8'h02);
    // player move in the expiry cycle beats the auto-move
    tick(TO - 1);
    move_valid = 1'b1; move_pos = 4'd5;
    tick();
    move_valid = 1'b0;
    check("to2_ack", {7'd0, move_ack}, 8'd1);
    check("to2_pos5", {6'd0, pos5}, 8'h02);
    check("to2_pos2", {6'd0, pos2}, 8'd0);
    tick();
    check("to2_turn", {6'd0, turn}, 8'h01);
    // invalid move at expiry: error, timer wraps, auto-move a full period later
    tick(TO - 1);
    move_valid = 1'b1; move_pos = 4'd1;
    tick();
    move_valid = 1'b0;
    check("to3_err", {7'd0, move_err}, 8'd1);
    check("to3_noack", {7'd0, move_ack}, 8'd0);
    check("to3_pos2", {6'd0, pos2}, 8'd0);
    tick(TO - 1);
    check("to3_pre_pos2", {6'd0, pos2}, 8'd0);
    check("to3_pre_ack", {7'd0, move_ack}, 8'd0);
    tick();
    check("to3_auto_pos2", {6'd0, pos2}, 8'h01);
    check("to3_auto_ack", {7'd0, move_ack}, 8'd1);

    // rst together with new_game lands in IDLE
    rst = 1'b1; new_game = 1'b1;
    tick();
    rst = 1'b0; new_game = 1'b0;
    check("rstng_turn", {6'd0, turn}, 8'd0);
    check("rstng_pos1", {6'd0, pos1}, 8'd0);
    check("rstng_pos2", {6'd0, pos2}, 8'd0);
    check("rstng_over", {7'd0, game_over}, 8'd0);
    tick();
    check("rstng_idle_turn", {6'd0, turn}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tictactoe_board_ctrl.md
# tictactoe_board_ctrl

Sequential board writer for the tic-tac-toe datapath. It accepts player moves, validates them, alternates turns, and holds the 9-cell board that drives `winner_detector` (pos1..pos9). It samples the detector's `winner`/`who` feedback to end the game, and declares a draw after 9 moves. A per-turn timeout auto-places the current player's mark in the lowest-numbered empty cell.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 250_000_000: cycles allowed per turn before an auto-move; must be ≥ 2.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `new_game`  in  1: clears the board and starts a game with P1 to move. Highest priority.
- `move_valid`  in  1: move request strobe, one cycle.
- `move_pos`  in  4: target cell, 1..9.
- `winner`  in  1: from `winner_detector`.
- `who`  in  2: from `winner_detector`; 01 = P1, 10 = P2.
- `pos1`..`pos9`  out  2 each: cell contents; 00 empty, 01 P1, 10 P2.
- `turn`  out  2: player to move (01/10); 00 when not in a turn state.
- `move_ack`  out  1: one-cycle pulse when a move (player or auto) is written.
- `move_err`  out  1: one-cycle pulse when a move is rejected.
- `game_over`  out  1: high in `OVER`.
- `result`  out  2: 00 none, 01 P1 wins, 10 P2 wins, 11 draw.

## Operation
- States: `IDLE`, `P1_TURN`, `P2_TURN`, `CHECK`, `OVER`.
- Reset: state `IDLE`; all pos = 00; turn = 00; move_ack = move_err = 0; game_over = 0; result = 00; move count = 0; timer = 0.
- `new_game` in any state (including mid-turn or `CHECK`):
  - clear board, move count and timer;
  - result = 00, game_over = 0;
  - next state `P1_TURN`.
- In `P1_TURN`/`P2_TURN` with `move_valid`:
  - Reject, with move_err pulse and no state/board change, if `move_pos` is 0 or >9, or if the target cell is non-empty. Timer keeps running.
  - Otherwise write the current player's code to the cell, pulse move_ack, increment the move count, clear the timer, and go to `CHECK`. The player who just moved is remembered.
- Timeout: the timer counts cycles in a turn state. When it reaches `TIMEOUT_CYCLES-1` with no `move_valid`, write the player's code to the lowest-numbered empty cell and handle it exactly as an accepted move (move_ack pulse).
- A `move_valid` in the expiry cycle takes precedence over the auto-move, even if that move is invalid (move_err; timer then wraps to 0).
- `CHECK` (one cycle; the detector sees the updated board combinationally):
  - if `winner`: result = `who`, go to `OVER`;
  - else if move count = 9: result = 11, go to `OVER`;
  - else go to the other player's turn.
- `move_valid` in `IDLE`, `CHECK`, or `OVER` is ignored: no ack, no err.
- `OVER` holds the board and result until `new_game` or `rst`.
- Move count is 4-bit, saturating at 9.

## Timing
- Move presented at cycle T:
  - board and move_ack/err visible at T+1;
  - state `CHECK` at T+1;
  - next turn or `OVER` (with result, game_over) at T+2.
- Minimum spacing between accepted moves is 2 cycles.
- `turn` is registered and valid in the same cycle as the turn state.
- `rst` takes effect at the next edge and overrides `new_game`.
- `new_game` at cycle T gives a cleared board and `P1_TURN` at T+1.

## Structure
- `tictactoe_pkg`:
  - cell codes `CELL_EMPTY=2'b00`, `CELL_P1=2'b01`, `CELL_P2=2'b10`;
  - result codes `RES_NONE`, `RES_P1`, `RES_P2`, `RES_DRAW`;
  - state enum `state_t`.
- Sub-module `turn_timer`: counter with `clear`/`en` inputs and an `expired` output, parameterised by `TIMEOUT_CYCLES`.
- Lowest-empty-cell search is a combinational priority encoder inside the top.
- Top-level test harness instantiates `winner_detector` and feeds its outputs back.

## Test plan
- rst, then new_game; moves P1:1, P2:4, P1:2, P2:5, P1:3 → result=01, game_over=1 two cycles after the last move; pos1..3=01.
- Full game with no line: 9 moves alternating (5,1,9,3,2,8,7,4,6) → result=11 after move 9.
- P2 targets an occupied cell, then pos 0, then pos 12 → three move_err pulses, board unchanged, turn stays 10.
- TIMEOUT_CYCLES=8, no move after new_game → at cycle 8 pos1=01 with move_ack, turn becomes 10; a move_valid exactly at expiry wins over the auto-move.
- new_game asserted during `CHECK` and during `OVER` → board cleared, `P1_TURN` next cycle; rst together with new_game → `IDLE`.
